fp32_writeback: RTL
===================

// Module: fp32_writeback
// PURPOSE
//  Downstream stage of the FP32 execute core. Pairs each core result with the destination register tag issued alongside it.
//  Buffers the paired results in a small FIFO and drains them to the register-file write port under valid/ready.
//  Accumulates sticky FP exception status (FPSR). Returns issue credit to dispatch, because the core itself cannot stall.
// PARAMETERS
//  DATA_WIDTH      32  result / register width
//  REG_ADDR_WIDTH   5  destination register index width
//  FIFO_DEPTH       4  writeback buffer entries (power of 2, >=2)
//  CORE_LATENCY     1  cycles from core issue to core_result_valid (>=1)
// PORTS
//  clk             in   1               clock
//  rst             in   1               reset, asynchronous, active-high
//  issue_valid     in   1               dispatch issued an FP op to the core this cycle
//  issue_rd        in   REG_ADDR_WIDTH  destination register of that op
//  issue_ready     out  1               credit available; dispatch may issue only when high
//  core_result_valid in 1               core result strobe
//  core_result     in   DATA_WIDTH      core result bits
//  core_overflow   in   1               core overflow flag
//  core_underflow  in   1               core underflow flag
//  core_nan        in   1               core NaN flag
//  rf_wr_en        out  1               register-file write request (valid)
//  rf_wr_ready     in   1               register file accepts the write
//  rf_wr_addr      out  REG_ADDR_WIDTH  write address
//  rf_wr_data      out  DATA_WIDTH      write data
//  fpsr_clear      in   1               clear all sticky FPSR bits
//  fpsr            out  6               sticky status {FIFO_OVF,ORPHAN,ILLEGAL,NV,UF,OF}
// BEHAVIOUR
//  Reset: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, fpsr=0, FIFO empty, tag line cleared, issue_ready=1.
//  Tag line: shift register CORE_LATENCY deep of {valid,rd}. Loads {issue_valid,issue_rd} every cycle; the head aligns with core_result_valid.
//  Pairing at the head each cycle:
//   - tag valid and result valid: push {rd,core_result}; OR core_overflow/underflow/nan into fpsr OF/UF/NV.
//   - tag valid, no result: the core rejected the opcode. Nothing is pushed; set ILLEGAL.
//   - result valid, no tag: discard the result; set ORPHAN.
//   - neither valid: no action.
//  FIFO:
//   - Push and pop in the same cycle is legal in every state, including full; count is unchanged.
//   - Push when full with no pop: the entry is dropped, FIFO_OVF is set, and FIFO contents are untouched.
//  Drain:
//   - rf_wr_en = !empty. rf_wr_addr/rf_wr_data come from the head entry.
//   - Pop on rf_wr_en && rf_wr_ready.
//   - Outputs stay stable while rf_wr_en && !rf_wr_ready.
//   - When rf_wr_en=0, rf_wr_addr/rf_wr_data are 0.
//  Latency: result cycle N -> rf_wr_en high at N+1 when the FIFO was empty (no bypass). Throughput is 1 write per cycle.
//  Credit: issue_ready = (count + inflight_tags) < FIFO_DEPTH. It is combinational from registered state only.
//   - A same-cycle pop is NOT credited (conservative).
//   - A compliant dispatch can therefore never cause FIFO_OVF.
//  FPSR:
//   - Bits are sticky.
//   - fpsr_clear clears all bits. A set event in the same cycle wins for its bit.
//   - Flags are accounted at pairing time, not at writeback.
//  Reset mid-operation: in-flight tags and FIFO entries are discarded. No rf write is issued after rst rises.
// STRUCTURE
//  fp_pkg:
//   - localparams FPSR_OF=0, FPSR_UF=1, FPSR_NV=2, FPSR_ILL=3, FPSR_ORPH=4, FPSR_OVF=5, FPSR_W=6.
//   - typedef struct packed {logic valid; logic [REG_ADDR_WIDTH-1:0] rd;} fp_tag_t.
//   - typedef struct packed wb_entry_t {rd, data}.
//  Sub-module: fp_wb_fifo, a synchronous FIFO of wb_entry_t.
//   - Ports push/pop/full/empty/count. Pointers are 1 bit wider than the index.
//  Top level: tag line, pairing logic, credit computation, FPSR register.
// TESTING
//  1. Issue rd=3, result 0x3F800000 one cycle later, rf_wr_ready=1 -> next cycle rf_wr_en=1, addr=3, data=0x3F800000, fpsr=0.
//  2. Hold rf_wr_ready=0 and issue back-to-back while issue_ready=1.
//     -> exactly 4 writes buffered, issue_ready=0, no FIFO_OVF.
//     -> release: writes drain in issue order, one per cycle.
//  3. Issue with core_result_valid=0 at the head -> no write, fpsr=6'b001000.
//     -> a result with no tag -> fpsr=6'b011000, no write.
//  4. Result with core_overflow=1 and core_nan=1 -> fpsr OF=1, NV=1.
//     -> fpsr_clear alone -> fpsr=0.
//     -> fpsr_clear coincident with a new overflow -> OF stays 1.
//  5. Force a push when full, bypassing credit -> FIFO_OVF=1, the 4 held entries are unchanged and drain intact.
//  6. Assert rst with 3 entries queued and 1 tag in flight -> rf_wr_en=0 immediately, fpsr=0, issue_ready=1, no stale write after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and status-bit positions for the FP32 writeback slice.
package fp_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   localparam int FPSR_OF   = 0;
   localparam int FPSR_UF   = 1;
   localparam int FPSR_NV   = 2;
   localparam int FPSR_ILL  = 3;
   localparam int FPSR_ORPH = 4;
   localparam int FPSR_OVF  = 5;
   localparam int FPSR_W    = 6;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
   } fp_tag_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/fp_wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module fp_wb_fifo
   import fp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wb_entry_t                  din,
   input  logic                       pop,
   output wb_entry_t                  dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the pointers alone decide what is live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
   end

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (count == PTR_W'(DEPTH));
   assign dout  = mem_q[rd_ptr_q[IDX_W-1:0]];
endmodule

// File: rtl/fp32_writeback.sv
// FP32 writeback stage: pairs core results with issued tags, buffers them,
// drains to the register file, tracks sticky FPSR and issue credit.
module fp32_writeback
   import fp_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH     = 4,
   parameter int CORE_LATENCY   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
   output logic                      issue_ready,
   input  logic                      core_result_valid,
   input  logic [DATA_WIDTH-1:0]     core_result,
   input  logic                      core_overflow,
   input  logic                      core_underflow,
   input  logic                      core_nan,
   output logic                      rf_wr_en,
   input  logic                      rf_wr_ready,
   output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [DATA_WIDTH-1:0]     rf_wr_data,
   input  logic                      fpsr_clear,
   output logic [5:0]                fpsr
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = $clog2(FIFO_DEPTH + CORE_LATENCY + 1) + 1;

   fp_tag_t           tag_q [CORE_LATENCY];
   fp_tag_t           tag_d [CORE_LATENCY];
   fp_tag_t           head_tag;
   logic [FPSR_W-1:0] fpsr_q, fpsr_d, fpsr_set;
   logic              pair_push, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [SUM_W-1:0]  inflight;
   wb_entry_t         push_entry, head_entry;

   always_comb begin
      tag_d[0] = '{valid: issue_valid, rd: issue_rd};
      for (int i = 1; i < CORE_LATENCY; i++) tag_d[i] = tag_q[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CORE_LATENCY; i++) tag_q[i] <= '0;
         fpsr_q <= '0;
      end else begin
         for (int i = 0; i < CORE_LATENCY; i++) tag_q[i] <= tag_d[i];
         fpsr_q <= fpsr_d;
      end
   end

   assign head_tag   = tag_q[CORE_LATENCY-1];
   assign pair_push  = head_tag.valid && core_result_valid;
   assign push_entry = '{rd: head_tag.rd, data: core_result};
   assign fifo_pop   = !fifo_empty && rf_wr_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign fifo_push  = pair_push && (!fifo_full || fifo_pop);

   always_comb begin
      fpsr_set            = '0;
      fpsr_set[FPSR_OF]   = pair_push && core_overflow;
      fpsr_set[FPSR_UF]   = pair_push && core_underflow;
      fpsr_set[FPSR_NV]   = pair_push && core_nan;
      fpsr_set[FPSR_ILL]  = head_tag.valid && !core_result_valid;
      fpsr_set[FPSR_ORPH] = !head_tag.valid && core_result_valid;
      fpsr_set[FPSR_OVF]  = pair_push && fifo_full && !fifo_pop;
      fpsr_d = (fpsr_clear ? '0 : fpsr_q) | fpsr_set;
   end

   fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Credit counts every tag still in the line, including the one pairing now.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < CORE_LATENCY; i++) inflight = inflight + SUM_W'(tag_q[i].valid);
      issue_ready = (SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH);
   end

   assign rf_wr_en   = !fifo_empty;
   assign rf_wr_addr = fifo_empty ? '0 : head_entry.rd;
   assign rf_wr_data = fifo_empty ? '0 : head_entry.data;
   assign fpsr       = fpsr_q;
endmodule
